// File: rtl/stream_fifo_if.sv
// Handshake bundle for stream_fifo: a write side (in_*) and a read side (out_*).
// The FIFO connects through the slave modport and the surrounding logic through master.
interface stream_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready handshakes on both
// sides and occupancy status. Pointers carry one extra wrap bit so full and
// empty can be told apart without a separate counter register.
module stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_fifo_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] AF_THR  = (AW + 1)'(AF_LEVEL);

    logic [AW:0]           wp_q;
    logic [AW:0]           wp_d;
    logic [AW:0]           rp_q;
    logic [AW:0]           rp_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push;
    logic                  pop;

    // Status is decoded purely from the registered pointers, so ready/valid
    // never depend combinationally on the partner's handshake inputs.
    assign count       = wp_q - rp_q;
    assign empty       = (wp_q == rp_q);
    assign full        = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign almost_full = (count >= AF_THR);

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem_q[rp_q[AW-1:0]];

    assign push = bus.in_valid  & ~full;
    assign pop  = bus.out_ready & ~empty;

    // Pointer next-state: each side advances by one on its own handshake.
    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (push) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (pop) begin
            rp_d = rp_q + PTR_ONE;
        end
    end

    // Pointer registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage array; cleared on reset so out_data reads 0 while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wp_q[AW-1:0]] <= bus.in_data;
        end
    end
endmodule
